// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-channel round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Round-robin priority pick: first set request at or above ptr, wrapping 3->0.
module rr_prio_pick
    import rr_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              any,
    output logic [SEL_W-1:0]  w
);

    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        any   = |req;
        w     = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = SEL_W'(32'(ptr) + i);
            if (!found && req[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4ch.sv
// Four-channel round-robin arbiter steering a downstream 4:1 mux.
// Optional grant timeout enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arb_4ch
    import rr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              done,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              valid,
    output logic              timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("rr_arb_4ch: TIMEOUT_CYCLES must be within 2..255");
    end

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             any;
    logic [SEL_W-1:0] w;
    logic             forced;
    logic             release_now;

    rr_prio_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .w   (w)
    );

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] busy_cnt;
    logic       timeout_q;

    assign forced  = (busy_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    // done and a request drop in the same cycle collapse into one release
    assign release_now = done || !req[sel] || forced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            sel       <= '0;
            valid     <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            busy_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any) begin
                        state    <= BUSY;
                        gnt      <= onehot(w);
                        sel      <= w;
                        valid    <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        busy_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        valid     <= 1'b0;
                        ptr       <= sel + 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        timeout_q <= forced && !done && req[sel];
`endif
                    end else begin
`ifdef RR_ARB_TIMEOUT_EN
                        busy_cnt  <= busy_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
